mem_access: RTL
===============

// Module: mem_access
// PURPOSE
//   MEM stage between EX_MEM and MEM_WB. Runs loads/stores on the data-SRAM-like bus (req/addr_ok/data_ok).
//   Aligns store data, sign/zero-extends load data, flags misaligned addresses, and stalls the pipeline until
//   the access completes. Register, HI/LO and CP0 writes pass through to MEM_WB unchanged.
// PARAMETERS
//   DW        32   data/address width
//   OPW       8    aluop width (`AluOpBus)
// PORTS
//   clk                 in   1   clock, all state updates on posedge
//   rst                 in   1   synchronous, active-high reset
//   stall               in   6   ctrl stall vector; stall[4] = this stage held
//   flush               in   1   exception flush, kills current instruction
//   ex_aluop            in   OPW operation from EX_MEM
//   ex_mem_addr         in   DW  effective address
//   ex_reg2             in   DW  store data
//   ex_wd/ex_wreg/ex_wdata  in 5/1/DW  GPR write from EX
//   ex_whilo/ex_hi/ex_lo, ex_cp0_reg_we/_write_addr/_data  in  passthrough group
//   mem_wd/mem_wreg/mem_wdata  out 5/1/DW  GPR write to MEM_WB (load result replaces ex_wdata)
//   mem_whilo/mem_hi/mem_lo, mem_cp0_reg_*  out  passthrough group
//   stallreq_mem        out  1   request ctrl to stall stages 0..4
//   exc_adel/exc_ades   out  1   misaligned load/store, address in exc_badvaddr (out DW)
//   data_req/data_wr    out  1   bus request / write
//   data_size           out  2   0=byte 1=half 2=word
//   data_addr/data_wdata out DW  bus address / lane-replicated store data
//   data_addr_ok/data_data_ok in 1  address accepted / data returned (write ack)
//   data_rdata          in   DW  read data
// BEHAVIOUR
//   Reset: state=IDLE; data_req=0, stallreq_mem=0, exc_*=0, result buffer=0. Passthroughs are combinational.
//   FSM IDLE -> REQ -> WAIT -> DONE; DRAIN used on flush only.
//   IDLE: non-memory op -> outputs pass through, stallreq=0. Memory op, aligned -> REQ same cycle
//     (data_req=1 combinationally, stallreq=1). Misaligned (half addr[0]!=0, word addr[1:0]!=0)
//     -> no request, exc_adel/ades=1, mem_wreg=0, store suppressed.
//   REQ: data_req held with stable addr/size/wdata until data_addr_ok; then -> WAIT, data_req=0.
//   WAIT: on data_data_ok, latch extended result into buffer -> DONE. stallreq=1 in REQ and WAIT.
//   DONE: stallreq=0; mem_wdata=buffer. -> IDLE when stall[4]==0 (MEM_WB captured); held while stall[4]==1,
//     no reissue.
//   Store data: SB replicates byte to all 4 lanes, SH replicates half to both, SW as-is.
//   Load extend: LB/LH sign-extend, LBU/LHU zero-extend, using lane addr[1:0]; little-endian.
//   One request outstanding max; addr_ok and data_ok in the same cycle -> REQ straight to DONE.
//   flush: IDLE/DONE -> IDLE. REQ with addr_ok=0 -> drop req, IDLE. REQ accepted or WAIT -> DRAIN:
//     stallreq=1, no new req, discard data; data_ok -> IDLE. Flushed op never writes GPR.
//   rst in any state -> IDLE immediately; bus is assumed reset together.
// STRUCTURE
//   Aluop codes (EXE_LB_OP..EXE_SW_OP), size codes and FSM encodings live in define.v.
//   One sub-module: mem_align (comb: store lane replication, load extraction/extension, misalign check).
// TESTING
//   LW 0x1000, addr_ok cycle 1, data_ok cycle 3, rdata=0xDEADBEEF -> stallreq 3 cycles, mem_wdata=0xDEADBEEF.
//   LB addr 0x1003, rdata=0x80FF_FF7F -> 0xFFFFFF80; LBU same -> 0x00000080; LH 0x1002 -> 0xFFFF80FF.
//   SB addr 0x2001, reg2=0x12345678 -> data_wdata=0x78787878, size=0, wr=1, mem_wreg=0.
//   LW addr 0x1002 -> exc_adel=1, badvaddr=0x1002, data_req never 1, stallreq=0.
//   flush during WAIT, data_ok 2 cycles later -> stallreq until data_ok, no write, next LW issues after.
//   DONE with stall[4]=1 for 3 cycles -> buffer held, data_req stays 0, one MEM_WB capture only.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared constants for the MEM stage: widths, aluop codes for loads/stores, bus size codes, FSM encodings.
package mem_access_pkg;

  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 8;
  localparam int unsigned RW  = 5;

  localparam logic [OPW-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [OPW-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [OPW-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [OPW-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [OPW-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [OPW-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [OPW-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [OPW-1:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

endpackage

// File: rtl/mem_access_align.sv
// Load/store decode, store lane replication, little-endian load extraction/extension, misalign check.
module mem_access_align
  import mem_access_pkg::*;
(
  input  logic [OPW-1:0] aluop,
  input  logic [1:0]     addr_lo,
  input  logic [DW-1:0]  reg2,
  input  logic [DW-1:0]  rdata,
  output logic           is_load_c,
  output logic           is_store_c,
  output logic           misaligned_c,
  output logic [1:0]     size_c,
  output logic [DW-1:0]  wdata_c,
  output logic [DW-1:0]  rdata_ext_c
);

  logic       sign_ext;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    is_load_c  = 1'b0;
    is_store_c = 1'b0;
    size_c     = SIZE_WORD;
    sign_ext   = 1'b0;
    case (aluop)
      EXE_LB_OP:  begin is_load_c  = 1'b1; size_c = SIZE_BYTE; sign_ext = 1'b1; end
      EXE_LBU_OP: begin is_load_c  = 1'b1; size_c = SIZE_BYTE; end
      EXE_LH_OP:  begin is_load_c  = 1'b1; size_c = SIZE_HALF; sign_ext = 1'b1; end
      EXE_LHU_OP: begin is_load_c  = 1'b1; size_c = SIZE_HALF; end
      EXE_LW_OP:  begin is_load_c  = 1'b1; size_c = SIZE_WORD; end
      EXE_SB_OP:  begin is_store_c = 1'b1; size_c = SIZE_BYTE; end
      EXE_SH_OP:  begin is_store_c = 1'b1; size_c = SIZE_HALF; end
      EXE_SW_OP:  begin is_store_c = 1'b1; size_c = SIZE_WORD; end
      default:    ;
    endcase
  end

  always_comb begin
    misaligned_c = (is_load_c || is_store_c) &&
                   (((size_c == SIZE_HALF) && addr_lo[0]) ||
                    ((size_c == SIZE_WORD) && (addr_lo != 2'b00)));
  end

  // Byte lane N of the bus carries address offset N.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (size_c)
      SIZE_BYTE: begin
        rdata_ext_c = {{24{sign_ext & byte_sel[7]}}, byte_sel};
        wdata_c     = {4{reg2[7:0]}};
      end
      SIZE_HALF: begin
        rdata_ext_c = {{16{sign_ext & half_sel[15]}}, half_sel};
        wdata_c     = {2{reg2[15:0]}};
      end
      default: begin
        rdata_ext_c = rdata;
        wdata_c     = reg2;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: drives the SRAM-like data bus, stalls until the access completes, buffers load data.
module mem_access
  import mem_access_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [5:0]     stall,
  input  logic           flush,
  input  logic [OPW-1:0] ex_aluop,
  input  logic [DW-1:0]  ex_mem_addr,
  input  logic [DW-1:0]  ex_reg2,
  input  logic [RW-1:0]  ex_wd,
  input  logic           ex_wreg,
  input  logic [DW-1:0]  ex_wdata,
  input  logic           ex_whilo,
  input  logic [DW-1:0]  ex_hi,
  input  logic [DW-1:0]  ex_lo,
  input  logic           ex_cp0_reg_we,
  input  logic [RW-1:0]  ex_cp0_reg_write_addr,
  input  logic [DW-1:0]  ex_cp0_reg_data,
  output logic [RW-1:0]  mem_wd,
  output logic           mem_wreg,
  output logic [DW-1:0]  mem_wdata,
  output logic           mem_whilo,
  output logic [DW-1:0]  mem_hi,
  output logic [DW-1:0]  mem_lo,
  output logic           mem_cp0_reg_we,
  output logic [RW-1:0]  mem_cp0_reg_write_addr,
  output logic [DW-1:0]  mem_cp0_reg_data,
  output logic           stallreq_mem,
  output logic           exc_adel,
  output logic           exc_ades,
  output logic [DW-1:0]  exc_badvaddr,
  output logic           data_req,
  output logic           data_wr,
  output logic [1:0]     data_size,
  output logic [DW-1:0]  data_addr,
  output logic [DW-1:0]  data_wdata,
  input  logic           data_addr_ok,
  input  logic           data_data_ok,
  input  logic [DW-1:0]  data_rdata
);

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] buf_q, buf_d;
  logic          is_load, is_store, misaligned, mem_op, issue_ok;
  logic          req_c, stall_c, exc_c;
  logic [1:0]    size;
  logic [DW-1:0] wdata_al, rdata_ext;
  logic          unused_stall_bits;

  assign unused_stall_bits = ^{stall[5], stall[3:0]};

  mem_access_align u_align (
    .aluop        (ex_aluop),
    .addr_lo      (ex_mem_addr[1:0]),
    .reg2         (ex_reg2),
    .rdata        (data_rdata),
    .is_load_c    (is_load),
    .is_store_c   (is_store),
    .misaligned_c (misaligned),
    .size_c       (size),
    .wdata_c      (wdata_al),
    .rdata_ext_c  (rdata_ext)
  );

  assign mem_op   = is_load | is_store;
  assign issue_ok = mem_op & ~misaligned & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  // An accepted request must always see its data phase; a flush after acceptance drains it.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    req_c   = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (issue_ok) begin
          req_c   = 1'b1;
          stall_c = 1'b1;
          if (data_addr_ok) begin
            if (data_data_ok) begin
              buf_d   = rdata_ext;
              state_d = ST_DONE;
            end else begin
              state_d = ST_WAIT;
            end
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (data_addr_ok) begin
          if (flush) begin
            state_d = data_data_ok ? ST_IDLE : ST_DRAIN;
          end else if (data_data_ok) begin
            buf_d   = rdata_ext;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        if (data_data_ok) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            buf_d   = rdata_ext;
            state_d = ST_DONE;
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (flush || !stall[4]) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        stall_c = 1'b1;
        if (data_data_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign exc_c        = mem_op & misaligned & ~flush & ~rst & (state_q == ST_IDLE);
  assign exc_adel     = exc_c & is_load;
  assign exc_ades     = exc_c & is_store;
  assign exc_badvaddr = exc_c ? ex_mem_addr : '0;

  assign data_req     = req_c & ~rst;
  assign stallreq_mem = stall_c & ~rst;
  assign data_wr      = is_store;
  assign data_size    = size;
  assign data_addr    = ex_mem_addr;
  assign data_wdata   = wdata_al;

  assign mem_wd    = ex_wd;
  assign mem_wreg  = ex_wreg & ~is_store & ~(mem_op & misaligned) & ~flush & (state_q != ST_DRAIN);
  assign mem_wdata = ((state_q == ST_DONE) && is_load) ? buf_q : ex_wdata;

  assign mem_whilo              = ex_whilo;
  assign mem_hi                 = ex_hi;
  assign mem_lo                 = ex_lo;
  assign mem_cp0_reg_we         = ex_cp0_reg_we;
  assign mem_cp0_reg_write_addr = ex_cp0_reg_write_addr;
  assign mem_cp0_reg_data       = ex_cp0_reg_data;

endmodule
